// File: rtl/i2c_line_filter_if.sv
// Pad-side and filtered-side signals of the I2C line filter.
// The filter takes the slave modport; whoever drives the raw pads takes the master modport.
interface i2c_line_filter_if;
    logic scl_in;
    logic sda_in;
    logic scl;
    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic bus_busy;
    logic fsm_state;   // debug view of the bus FSM: 0 = IDLE, 1 = BUSY

    modport master (
        output scl_in, sda_in,
        input  scl, sda, scl_rise, scl_fall, start_det, stop_det, bus_busy, fsm_state
    );

    modport slave (
        input  scl_in, sda_in,
        output scl, sda, scl_rise, scl_fall, start_det, stop_det, bus_busy, fsm_state
    );
endinterface

// File: rtl/i2c_line_filter.sv
// Synchronizes and glitch-filters raw SCL/SDA, then derives SCL edge, START/STOP
// pulses and a bus-busy flag from the filtered lines.
module i2c_line_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    i2c_line_filter_if.slave  bus
);
    localparam int            CW       = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Index 0 is SCL, index 1 is SDA.
    logic [1:0]    w_raw;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_filt;
    logic [CW-1:0] r_cnt [2];
    logic [1:0]    w_filt_next;

    logic   w_scl_rise;
    logic   w_scl_fall;
    logic   w_start;
    logic   w_stop;
    state_t r_state;
    logic   r_busy;
    logic   r_scl_rise;
    logic   r_scl_fall;
    logic   r_start;
    logic   r_stop;

    assign w_raw = {bus.sda_in, bus.scl_in};

    // The filtered value flips on the cycle the counter would reach FILT_LEN.
    always_comb begin
        w_filt_next = r_filt;
        for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] != r_filt[i] && r_cnt[i] == CNT_LAST) begin
                w_filt_next[i] = r_sync2[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
            r_filt  <= 2'b11;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_filt  <= w_filt_next;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i] || r_cnt[i] == CNT_LAST) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Events are judged on the transition the filtered lines are about to make,
    // so the registered pulses line up with the first cycle of the new value.
    assign w_scl_rise = ~r_filt[0] &  w_filt_next[0];
    assign w_scl_fall =  r_filt[0] & ~w_filt_next[0];
    assign w_start    =  r_filt[0] &  w_filt_next[0] &  r_filt[1] & ~w_filt_next[1];
    assign w_stop     =  r_filt[0] &  w_filt_next[0] & ~r_filt[1] &  w_filt_next[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_rise <= w_scl_rise;
            r_scl_fall <= w_scl_fall;
            r_start    <= w_start;
            r_stop     <= w_stop;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= BUSY;
                        r_busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (w_stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.scl       = r_filt[0];
    assign bus.sda       = r_filt[1];
    assign bus.scl_rise  = r_scl_rise;
    assign bus.scl_fall  = r_scl_fall;
    assign bus.start_det = r_start;
    assign bus.stop_det  = r_stop;
    assign bus.bus_busy  = r_busy;
    assign bus.fsm_state = r_state;
endmodule

// File: tb/tb_i2c_line_filter.sv
// Directed bench for i2c_line_filter with FILT_LEN=4: glitch rejection, START,
// repeated START, STOP, simultaneous falls, and reset mid-transaction.
module tb_i2c_line_filter;
    localparam int L = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   n_start;
    int   n_stop;
    int   n_rise;
    int   n_fall;
    int   n_excl;
    int   s0;
    int   p0;
    int   r0;
    int   f0;

    i2c_line_filter_if bus ();

    i2c_line_filter #(.FILT_LEN(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse monitor, sampled 2ns after each rising edge
    always @(posedge clk) begin
        #2;
        if (bus.start_det) n_start++;
        if (bus.stop_det)  n_stop++;
        if (bus.scl_rise)  n_rise++;
        if (bus.scl_fall)  n_fall++;
        if ((bus.start_det && bus.stop_det) || (bus.scl_rise && bus.scl_fall)) n_excl++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        n_start = 0; n_stop = 0; n_rise = 0; n_fall = 0; n_excl = 0;
        rst_n = 1'b0;
        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;

        // reset state, held without release
        tick(3);
        check("rst_scl", bus.scl, 1);
        check("rst_sda", bus.sda, 1);
        check("rst_busy", bus.bus_busy, 0);
        check("rst_state", bus.fsm_state, 0);
        check("rst_pulses", {bus.scl_rise, bus.scl_fall, bus.start_det, bus.stop_det}, 0);
        rst_n = 1'b1;
        tick(8);

        // 3-cycle SDA glitch with SCL high is rejected
        s0 = n_start;
        bus.sda_in = 1'b0;
        tick(3);
        bus.sda_in = 1'b1;
        tick(12);
        check("glitch_sda", bus.sda, 1);
        check("glitch_nostart", n_start - s0, 0);

        // START: sda falls exactly 6 cycles after the raw change
        bus.sda_in = 1'b0;
        tick(5);
        check("start_pre_sda", bus.sda, 1);
        check("start_pre_det", bus.start_det, 0);
        tick(1);
        check("start_sda", bus.sda, 0);
        check("start_det", bus.start_det, 1);
        check("start_busy", bus.bus_busy, 1);
        tick(1);
        check("start_det_end", bus.start_det, 0);
        check("start_busy_hold", bus.bus_busy, 1);

        // 8 SCL toggles, SDA released while SCL low, then repeated START
        s0 = n_start; p0 = n_stop; r0 = n_rise; f0 = n_fall;
        for (int i = 0; i < 8; i++) begin
            bus.scl_in = (i % 2 == 1);
            if (i == 0) begin
                tick(6);
                check("fall_scl", bus.scl, 0);
                check("fall_pulse", bus.scl_fall, 1);
                tick(1);
                check("fall_pulse_end", bus.scl_fall, 0);
                tick(1);
                bus.sda_in = 1'b1;
                tick(8);
            end else begin
                tick(16);
            end
        end
        check("toggle_rise_cnt", n_rise - r0, 4);
        check("toggle_fall_cnt", n_fall - f0, 4);
        check("toggle_no_start", n_start - s0, 0);
        check("toggle_no_stop", n_stop - p0, 0);
        check("toggle_busy", bus.bus_busy, 1);
        bus.sda_in = 1'b0;
        tick(6);
        check("rstart_det", bus.start_det, 1);
        check("rstart_busy", bus.bus_busy, 1);
        tick(4);

        // STOP while busy
        bus.sda_in = 1'b1;
        tick(5);
        check("stop_pre_det", bus.stop_det, 0);
        check("stop_pre_busy", bus.bus_busy, 1);
        tick(1);
        check("stop_det", bus.stop_det, 1);
        check("stop_busy", bus.bus_busy, 0);
        check("stop_sda", bus.sda, 1);
        tick(1);
        check("stop_det_end", bus.stop_det, 0);
        tick(4);

        // both lines fall together: SCL edge only
        s0 = n_start;
        bus.scl_in = 1'b0;
        bus.sda_in = 1'b0;
        tick(6);
        check("both_scl_fall", bus.scl_fall, 1);
        check("both_scl", bus.scl, 0);
        check("both_sda", bus.sda, 0);
        check("both_no_start", n_start - s0, 0);
        check("both_busy", bus.bus_busy, 0);

        // SCL up, then SDA up: STOP in IDLE pulses but stays IDLE
        bus.scl_in = 1'b1;
        tick(10);
        bus.sda_in = 1'b1;
        tick(6);
        check("idle_stop_det", bus.stop_det, 1);
        check("idle_stop_busy", bus.bus_busy, 0);
        tick(4);

        // reset mid-transaction, released with both raw lines low
        bus.sda_in = 1'b0;
        tick(8);
        check("pre_rst_busy", bus.bus_busy, 1);
        bus.scl_in = 1'b0;
        tick(3);
        rst_n = 1'b0;
        #1;
        check("async_busy", bus.bus_busy, 0);
        check("async_scl", bus.scl, 1);
        check("async_sda", bus.sda, 1);
        tick(2);
        s0 = n_start; p0 = n_stop; f0 = n_fall;
        rst_n = 1'b1;
        tick(5);
        check("rel_pre_scl", bus.scl, 1);
        tick(1);
        check("rel_scl", bus.scl, 0);
        check("rel_sda", bus.sda, 0);
        check("rel_scl_fall", bus.scl_fall, 1);
        tick(3);
        check("rel_no_start", n_start - s0, 0);
        check("rel_no_stop", n_stop - p0, 0);
        check("rel_fall_cnt", n_fall - f0, 1);
        check("rel_busy", bus.bus_busy, 0);

        check("exclusive_pulses", n_excl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
